// File: rtl/sha_padder_if.sv
// sha_padder_if: word-stream input and block-stream output of sha_padder.
// master = message source / block consumer, slave = the padder itself.
interface sha_padder_if;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_data;
   logic [3:0]    in_bytes;
   logic          in_last;
   logic [2:0]    in_mode;
   logic          out_valid;
   logic          out_ready;
   logic [1023:0] out_block;
   logic [2:0]    out_mode;
   logic          out_first;
   logic          out_last;

   modport master (
      output in_valid, in_data, in_bytes, in_last, in_mode, out_ready,
      input  in_ready, out_valid, out_block, out_mode, out_first, out_last
   );

   modport slave (
      input  in_valid, in_data, in_bytes, in_last, in_mode, out_ready,
      output in_ready, out_valid, out_block, out_mode, out_first, out_last
   );
endinterface

// File: rtl/sha_padder.sv
// sha_padder: packs a big-endian word stream into SHA-1/2 message blocks with 0x80, zero fill and length.
// Optional SHA_PADDER_ERR_EN adds a sticky err output flagging malformed input words.
module sha_padder #(
   parameter int unsigned LEN_W = 64
) (
   input  logic       clk,
   input  logic       rst,
`ifdef SHA_PADDER_ERR_EN
   output logic       err,
`endif
   sha_padder_if.slave bus
);

   localparam logic [2:0] MODE_SHA1   = 3'd0;
   localparam logic [2:0] MODE_SHA384 = 3'd3;
   localparam logic [2:0] MODE_SHA512 = 3'd4;

   typedef enum logic [2:0] {IDLE, FILL, PAD, OUT, EXTRA} state_t;

   state_t            state;
   logic [63:0]       blk [16];
   logic [3:0]        widx;
   logic [3:0]        lidx;
   logic [LEN_W-1:0]  len;
   logic              first_pend;
   logic              pad80_pend;
   logic              extra_pend;
   logic              blk_valid;
   logic              blk_first;
   logic              blk_last;
   logic [2:0]        blk_mode;

   logic              accept;
   logic [2:0]        mode_eff;
   logic              wide;
   logic [3:0]        lane_bytes;
   logic [3:0]        nbc;
   logic [3:0]        slot;
   logic [LEN_W-1:0]  len_base;
   logic [LEN_W-1:0]  len_sum;
`ifdef SHA_PADDER_ERR_EN
   logic              len_carry;
`endif
   logic [63:0]       word;
   logic [5:0]        pos;
   logic [63:0]       lane80;
   logic [127:0]      len128;
   logic [63:0]       len_hi;
   logic [63:0]       len_lo;
   logic [4:0]        end_idx;
   logic              room;
   logic [1023:0]     block_flat;

   assign bus.in_ready  = !rst && (state == IDLE || state == FILL);
   assign bus.out_valid = blk_valid;
   assign bus.out_first = blk_first;
   assign bus.out_last  = blk_last;
   assign bus.out_mode  = blk_mode;
   assign bus.out_block = block_flat;
   assign accept        = bus.in_valid && bus.in_ready;

   always_comb begin
      block_flat = '0;
      for (int unsigned s = 0; s < 16; s++) begin
         block_flat[1023-64*s -: 64] = blk[s];
      end
   end

   // The first word of a message uses in_mode and a zero length base; later words use the latched mode.
   always_comb begin
      mode_eff   = (state == IDLE) ? bus.in_mode : blk_mode;
      wide       = (mode_eff == MODE_SHA384) || (mode_eff == MODE_SHA512);
      lane_bytes = wide ? 4'd8 : 4'd4;
      nbc        = (bus.in_bytes > lane_bytes) ? lane_bytes : bus.in_bytes;
      slot       = (state == IDLE) ? 4'd0 : widx;
      len_base   = (state == IDLE) ? '0 : len;
`ifdef SHA_PADDER_ERR_EN
      {len_carry, len_sum} = {1'b0, len_base} + {{(LEN_W-6){1'b0}}, nbc, 3'b000};
`else
      len_sum = len_base + {{(LEN_W-7){1'b0}}, nbc, 3'b000};
`endif
      word = '0;
      pos  = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         if (wide || k < 4) begin
            pos = wide ? 6'(56 - 8*k) : 6'(24 - 8*k);
            if (k < 32'(nbc)) begin
               word[pos +: 8] = bus.in_data[pos +: 8];
            end else if (bus.in_last && k == 32'(nbc)) begin
               word[pos +: 8] = 8'h80;
            end
         end
      end
      lane80  = wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      len128  = 128'(len);
      len_hi  = wide ? len128[127:64] : {32'b0, len128[63:32]};
      len_lo  = wide ? len128[63:0]   : {32'b0, len128[31:0]};
      // Index of the last non-length word, counting a pending 0x80 word; may reach 16.
      end_idx = {1'b0, lidx} + {4'b0, pad80_pend};
      room    = (end_idx <= 5'd13);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         for (int unsigned s = 0; s < 16; s++) blk[s] <= '0;
         widx       <= '0;
         lidx       <= '0;
         len        <= '0;
         first_pend <= 1'b0;
         pad80_pend <= 1'b0;
         extra_pend <= 1'b0;
         blk_valid  <= 1'b0;
         blk_first  <= 1'b0;
         blk_last   <= 1'b0;
         blk_mode   <= MODE_SHA1;
      end else begin
         unique case (state)
            IDLE, FILL: begin
               if (accept) begin
                  blk[slot] <= word;
                  len       <= len_sum;
                  if (state == IDLE) begin
                     blk_mode   <= bus.in_mode;
                     first_pend <= 1'b1;
                  end
                  if (bus.in_last) begin
                     lidx       <= slot;
                     pad80_pend <= (nbc == lane_bytes);
                     state      <= PAD;
                  end else if (slot == 4'd15) begin
                     widx      <= '0;
                     blk_valid <= 1'b1;
                     blk_first <= first_pend;
                     blk_last  <= 1'b0;
                     state     <= OUT;
                  end else begin
                     widx  <= slot + 4'd1;
                     state <= FILL;
                  end
               end
            end
            PAD: begin
               for (int unsigned s = 0; s < 16; s++) begin
                  if (5'(s) > {1'b0, lidx}) begin
                     blk[s] <= (pad80_pend && 5'(s) == {1'b0, lidx} + 5'd1) ? lane80 : 64'd0;
                  end
               end
               if (lidx != 4'd15) pad80_pend <= 1'b0;
               if (room) begin
                  blk[14] <= len_hi;
                  blk[15] <= len_lo;
               end
               extra_pend <= !room;
               blk_last   <= room;
               blk_first  <= first_pend;
               blk_valid  <= 1'b1;
               state      <= OUT;
            end
            OUT: begin
               if (bus.out_ready) begin
                  blk_valid  <= 1'b0;
                  blk_first  <= 1'b0;
                  blk_last   <= 1'b0;
                  first_pend <= 1'b0;
                  if (extra_pend) begin
                     state <= EXTRA;
                  end else if (blk_last) begin
                     state <= IDLE;
                  end else begin
                     widx  <= '0;
                     state <= FILL;
                  end
               end
            end
            EXTRA: begin
               for (int unsigned s = 1; s < 14; s++) blk[s] <= '0;
               blk[0]     <= pad80_pend ? lane80 : 64'd0;
               blk[14]    <= len_hi;
               blk[15]    <= len_lo;
               pad80_pend <= 1'b0;
               extra_pend <= 1'b0;
               blk_last   <= 1'b1;
               blk_first  <= first_pend;
               blk_valid  <= 1'b1;
               state      <= OUT;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SHA_PADDER_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (accept && ((bus.in_bytes > lane_bytes) ||
                              (bus.in_bytes < lane_bytes && !bus.in_last) ||
                              (state == FILL && bus.in_mode != blk_mode) ||
                              len_carry)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sha_padder.sv
// tb_sha_padder: directed known-answer cases plus random messages checked against a byte-level padding model.
module tb_sha_padder;
   logic clk = 1'b0;
   logic rst;
   int   compared = 0;
   int   mism = 0;

   logic [7:0]    msg[$];
   logic [63:0]   wdata[$];
   logic [3:0]    wbytes[$];
   logic          wlast[$];
   logic [1023:0] exp_blk[$];
   logic [1023:0] got_blk[$];
   logic [1023:0] e;

   sha_padder_if bus();
`ifdef SHA_PADDER_ERR_EN
   logic err;
`endif

   sha_padder #(.LEN_W(64)) dut (
      .clk (clk),
      .rst (rst),
`ifdef SHA_PADDER_ERR_EN
      .err (err),
`endif
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] word_at(input logic [1023:0] b, input int s);
      return b[1023-64*s -: 64];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_blk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      int fs;
      compared++;
      assert (obs === exp) else begin
         mism++;
         fs = 0;
         for (int s = 15; s >= 0; s--) if (word_at(obs, s) !== word_at(exp, s)) fs = s;
         $error("FAIL %s: slot %0d got %h expected %h", tag, fs, word_at(obs, fs), word_at(exp, fs));
      end
   endtask

   // Reference: pad the byte message per FIPS 180-4 and cut it into 16-word blocks.
   task automatic build_exp(input logic [2:0] mode);
      logic [7:0]    p[$];
      logic [127:0]  bitlen;
      logic [1023:0] b;
      logic [63:0]   w;
      int            bsz, lf, lb;
      bit            wide;
      wide = (mode >= 3'd3);
      bsz  = wide ? 128 : 64;
      lf   = wide ? 16 : 8;
      lb   = wide ? 8 : 4;
      p = msg;
      p.push_back(8'h80);
      while ((p.size() % bsz) != bsz - lf) p.push_back(8'h00);
      bitlen = 128'(msg.size()) << 3;
      for (int i = lf - 1; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
      exp_blk.delete();
      for (int bi = 0; bi < p.size() / bsz; bi++) begin
         b = '0;
         for (int s = 0; s < 16; s++) begin
            w = '0;
            for (int k = 0; k < lb; k++) w = (w << 8) | 64'(p[bi*bsz + s*lb + k]);
            b[1023-64*s -: 64] = w;
         end
         exp_blk.push_back(b);
      end
   endtask

   // Split msg into input words; unused byte lanes carry garbage the padder must drop.
   task automatic build_words(input logic [2:0] mode);
      int          lb, n, idx, nb;
      bit          wide, extra0;
      logic [63:0] d;
      wide   = (mode >= 3'd3);
      lb     = wide ? 8 : 4;
      n      = msg.size();
      idx    = 0;
      extra0 = ($urandom_range(3) == 0);
      wdata.delete(); wbytes.delete(); wlast.delete();
      if (n == 0) begin
         wdata.push_back({$urandom, $urandom}); wbytes.push_back(4'd0); wlast.push_back(1'b1);
      end
      while (idx < n) begin
         nb = (n - idx < lb) ? n - idx : lb;
         d  = {$urandom, $urandom};
         for (int k = 0; k < nb; k++) begin
            if (wide) d[63-8*k -: 8] = msg[idx+k];
            else      d[31-8*k -: 8] = msg[idx+k];
         end
         wdata.push_back(d);
         wbytes.push_back(4'(nb));
         wlast.push_back((idx + nb == n) && !(nb == lb && extra0));
         idx += nb;
      end
      if (n > 0 && (n % lb) == 0 && extra0) begin
         wdata.push_back({$urandom, $urandom}); wbytes.push_back(4'd0); wlast.push_back(1'b1);
      end
   endtask

   task automatic run_msg(input logic [2:0] mode, input int unsigned bp, input string tag);
      int unsigned wi, cyc, idx;
      build_exp(mode);
      build_words(mode);
      got_blk.delete();
      wi = 0;
      cyc = 0;
      while (got_blk.size() < exp_blk.size() && cyc < 5000) begin
         if (wi < wdata.size()) begin
            bus.in_valid = 1'b1;
            bus.in_data  = wdata[wi];
            bus.in_bytes = wbytes[wi];
            bus.in_last  = wlast[wi];
         end else begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
         end
         bus.in_mode   = (wi == 0) ? mode : 3'($urandom_range(7));
         bus.out_ready = ($urandom_range(99) >= bp);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            idx = got_blk.size();
            chk_blk({tag, "_blk"}, bus.out_block, exp_blk[idx]);
            chk({tag, "_first"}, 64'(bus.out_first), 64'(idx == 0));
            chk({tag, "_last"}, 64'(bus.out_last), 64'(idx == exp_blk.size() - 1));
            chk({tag, "_mode"}, 64'(bus.out_mode), 64'(mode));
            got_blk.push_back(bus.out_block);
         end
         if (bus.in_valid && bus.in_ready) wi++;
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      chk({tag, "_in_time"}, 64'(cyc < 5000), 64'd1);
      chk({tag, "_words"}, 64'(wi), 64'(wdata.size()));
      #1 chk({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_bytes = '0; bus.in_last = 1'b0;
      bus.in_mode = '0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_first_last", 64'({bus.out_first, bus.out_last}), 64'd0);
      chk("rst_mode", 64'(bus.out_mode), 64'd0);
      chk_blk("rst_block", bus.out_block, '0);
      rst = 1'b0;
      #1 chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);

      // sha256 "abc" with latency and five cycles of backpressure
      e = '0; e[1023 -: 64] = 64'h61626380; e[63:0] = 64'h18;
      bus.in_valid = 1'b1; bus.in_data = {32'hDEADBEEF, 32'h616263AA};
      bus.in_bytes = 4'd3; bus.in_last = 1'b1; bus.in_mode = 3'd2;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      chk("lat_n1_valid", 64'(bus.out_valid), 64'd0);
      chk("pad_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); @(negedge clk);
      chk("lat_n2_valid", 64'(bus.out_valid), 64'd1);
      for (int c = 0; c < 5; c++) begin
         chk_blk("bp_block", bus.out_block, e);
         chk("bp_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_first_last", 64'({bus.out_first, bus.out_last}), 64'd3);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         @(posedge clk); @(negedge clk);
      end
      bus.out_ready = 1'b1;
      chk_blk("abc256_block", bus.out_block, e);
      chk("abc256_mode", 64'(bus.out_mode), 64'd2);
      @(posedge clk); @(negedge clk);
      bus.out_ready = 1'b0;
      chk("post_valid", 64'(bus.out_valid), 64'd0);
      chk("post_in_ready", 64'(bus.in_ready), 64'd1);

      // 64 bytes: full block one cycle after the 16th word, then a length-only block
      msg.delete();
      repeat (64) msg.push_back(8'($urandom_range(255)));
      build_exp(3'd2);
      for (int w = 0; w < 16; w++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = {$urandom, msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]};
         bus.in_bytes = 4'd4; bus.in_last = 1'b0;
         bus.in_mode  = (w == 0) ? 3'd2 : 3'($urandom_range(7));
         #1 chk("fill_ready", 64'(bus.in_ready), 64'd1);
         @(posedge clk); @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("full_lat_valid", 64'(bus.out_valid), 64'd1);
      chk_blk("full_block", bus.out_block, exp_blk[0]);
      chk("full_first_last", 64'({bus.out_first, bus.out_last}), 64'd2);
      bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.out_ready = 1'b0;
      chk("refill_ready", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1; bus.in_data = {$urandom, $urandom}; bus.in_bytes = 4'd0; bus.in_last = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      chk("tail_n1_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); @(negedge clk);
      chk("tail_n2_valid", 64'(bus.out_valid), 64'd1);
      chk_blk("tail_block", bus.out_block, exp_blk[1]);
      chk("tail_w0", word_at(bus.out_block, 0), 64'h80000000);
      chk("tail_w15", word_at(bus.out_block, 15), 64'h200);
      chk("tail_first_last", 64'({bus.out_first, bus.out_last}), 64'd1);
      bus.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.out_ready = 1'b0;

      // reset in the middle of a sha512 message, then a clean "abc"
      for (int w = 0; w < 7; w++) begin
         bus.in_valid = 1'b1; bus.in_data = {$urandom, $urandom};
         bus.in_bytes = 4'd8; bus.in_last = 1'b0; bus.in_mode = 3'd4;
         @(posedge clk); @(negedge clk);
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_first_last", 64'({bus.out_first, bus.out_last}), 64'd0);
      chk("mid_rst_mode", 64'(bus.out_mode), 64'd0);
      chk_blk("mid_rst_block", bus.out_block, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      msg = '{8'h61, 8'h62, 8'h63};
      run_msg(3'd2, 0, "abc256_after_rst");
      chk_blk("abc256_after_rst_const", got_blk[0], e);

      msg.delete();
      run_msg(3'd2, 20, "empty256");
      e = '0; e[1023 -: 64] = 64'h80000000;
      chk_blk("empty256_const", got_blk[0], e);

      msg.delete();
      repeat (56) msg.push_back(8'($urandom_range(255)));
      run_msg(3'd2, 30, "b56_256");
      chk("b56_w14", word_at(got_blk[0], 14), 64'h80000000);
      chk("b56_w15", word_at(got_blk[0], 15), 64'h0);
      chk("b56_blk2_w15", word_at(got_blk[1], 15), 64'h1C0);

      msg = '{8'h61, 8'h62, 8'h63};
      run_msg(3'd4, 0, "abc512");
      e = '0; e[1023 -: 64] = 64'h6162638000000000; e[63:0] = 64'h18;
      chk_blk("abc512_const", got_blk[0], e);

      msg.delete();
      repeat (128) msg.push_back(8'($urandom_range(255)));
      run_msg(3'd4, 25, "b128_512");
      chk("b128_blk2_w0", word_at(got_blk[1], 0), 64'h8000000000000000);
      chk("b128_blk2_w15", word_at(got_blk[1], 15), 64'h400);

      for (int m = 0; m < 24; m++) begin
         msg.delete();
         repeat ($urandom_range(300)) msg.push_back(8'($urandom_range(255)));
         run_msg(3'($urandom_range(4)), $urandom_range(60), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end
endmodule
